qbus_target: RTL and testbench



---
 rtl/qbus_pkg.sv | 17 +
 rtl/qbus_target_lanes.sv | 23 ++
 rtl/qbus_target.sv | 153 +++++++++++++++
 tb/tb_qbus_target.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/qbus_pkg.sv
// Shared encodings for the qbus target: FSM states, byte-enable patterns and
// the data returned when a read times out.
package qbus_pkg;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WAIT    = 3'd1;
  localparam logic [2:0] S_REQ     = 3'd2;
  localparam logic [2:0] S_REPLY   = 3'd3;
  localparam logic [2:0] S_RELEASE = 3'd4;

  localparam logic [1:0] BE_WORD = 2'b11;
  localparam logic [1:0] BE_LO   = 2'b01;
  localparam logic [1:0] BE_HI   = 2'b10;

  localparam logic [15:0] READ_TIMEOUT_DATA = 16'hFFFF;

endpackage

// File: rtl/qbus_target_lanes.sv
// Write-lane steering: byte writes select one lane by address bit 0 and
// replicate the low byte; reads and word writes use both lanes.
module qbus_target_lanes
  import qbus_pkg::*;
(
  input  logic        is_read,
  input  logic        wtbt,
  input  logic        a0,
  input  logic [15:0] data,
  output logic [1:0]  be,
  output logic [15:0] wdata
);

  always_comb begin
    be    = BE_WORD;
    wdata = data;
    if (!is_read && wtbt) begin
      be    = a0 ? BE_HI : BE_LO;
      wdata = {data[7:0], data[7:0]};
    end
  end

endmodule

// File: rtl/qbus_target.sv
// Bus responder for the vm1 MPI-style bus: window decode, optional wait states,
// single-beat backend request with timeout, RPLY held until strobes release.
module qbus_target
  import qbus_pkg::*;
#(
  parameter logic [15:0] BASE        = 16'o100000,
  parameter logic [15:0] MASK        = 16'o140000,
  parameter int          WAIT_STATES = 0,
  parameter int          TIMEOUT     = 63
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic [15:0] addr_i,
  input  logic [15:0] data_i,
  output logic [15:0] data_o,
  input  logic        SYNC,
  input  logic        DIN,
  input  logic        DOUT,
  input  logic        WTBT,
  output logic        RPLY,
  output logic [14:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [1:0]  mem_be,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic        err_o
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);
  localparam logic [7:0] TMO_LOAD  = 8'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

  logic [2:0]  state_q, state_d;
  logic        strb_q, strb_d;
  logic [14:0] addr_q, addr_d;
  logic        rd_q, rd_d;
  logic [1:0]  be_q, be_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] data_q, data_d;
  logic        err_q, err_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic [7:0]  tcnt_q, tcnt_d;

  logic [1:0]  lane_be;
  logic [15:0] lane_wdata;
  logic        strobe, start, hit, abort;

  assign strobe = DIN | DOUT;
  assign start  = SYNC & strobe & ~strb_q;
  assign hit    = (addr_i & MASK) == (BASE & MASK);
  assign abort  = ~SYNC & ~DIN & ~DOUT;

  // DIN wins when both strobes are raised together
  qbus_target_lanes u_lanes (
    .is_read (DIN),
    .wtbt    (WTBT),
    .a0      (addr_i[0]),
    .data    (data_i),
    .be      (lane_be),
    .wdata   (lane_wdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      strb_q  <= 1'b0;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      wcnt_q  <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      strb_q  <= strb_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
      err_q   <= err_d;
      wcnt_q  <= wcnt_d;
      tcnt_q  <= tcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    strb_d  = strb_q;
    addr_d  = addr_q;
    rd_d    = rd_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    data_d  = data_q;
    err_d   = err_q;
    wcnt_d  = wcnt_q;
    tcnt_d  = tcnt_q;
    if (ce) begin
      strb_d = strobe;
      err_d  = 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start && hit) begin
            addr_d  = addr_i[15:1];
            rd_d    = DIN;
            be_d    = lane_be;
            wdata_d = lane_wdata;
            wcnt_d  = WAIT_LOAD;
            tcnt_d  = TMO_LOAD;
            state_d = (WAIT_STATES > 0) ? S_WAIT : S_REQ;
          end
        end
        S_WAIT: begin
          if (abort)                state_d = S_IDLE;
          else if (wcnt_q == 4'd0)  state_d = S_REQ;
          else                      wcnt_d  = wcnt_q - 4'd1;
        end
        // ack is checked before the terminal count so a coincident ack wins
        S_REQ: begin
          if (mem_ack) begin
            if (rd_q) data_d = mem_rdata;
            state_d = S_REPLY;
          end else if (tcnt_q == 8'd0) begin
            if (rd_q) data_d = READ_TIMEOUT_DATA;
            err_d   = 1'b1;
            state_d = S_REPLY;
          end else begin
            tcnt_d = tcnt_q - 8'd1;
          end
        end
        S_REPLY:   if (!strobe) state_d = S_RELEASE;
        S_RELEASE: state_d = S_IDLE;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    RPLY      = (state_q == S_REPLY);
    mem_rd    = (state_q == S_REQ) &  rd_q;
    mem_wr    = (state_q == S_REQ) & ~rd_q;
    mem_addr  = addr_q;
    mem_be    = be_q;
    mem_wdata = wdata_q;
    data_o    = data_q;
    err_o     = err_q;
  end

endmodule

// File: tb/tb_qbus_target.sv
// Scoreboard bench for qbus_target: two instances on one bus (no wait states and
// three wait states) with a behavioural backend that acks after a set delay.
module tb_qbus_target;

  localparam int TMO = 63;

  typedef struct packed {
    logic [14:0] addr;
    logic [1:0]  be;
    logic [15:0] wdata;
    logic        wr;
  } mexp_t;

  typedef struct packed {
    logic [15:0] data;
    logic        rd;
    logic        err;
  } rexp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce  = 1'b1;
  logic [15:0] addr_i = '0;
  logic [15:0] data_i = '0;
  logic        SYNC = 1'b0, DIN = 1'b0, DOUT = 1'b0, WTBT = 1'b0;

  logic [15:0] d_o [2];
  logic        rply [2];
  logic        m_rd [2];
  logic        m_wr [2];
  logic        m_ack [2];
  logic        err [2];
  logic [14:0] m_addr [2];
  logic [1:0]  m_be [2];
  logic [15:0] m_wdata [2];
  logic [15:0] m_rdata [2];

  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  int    ack_lat [2];
  int    req_cnt [2];
  int    req_start [2];
  bit    any_req [2];
  int    WS [2];
  mexp_t mq [2][$];
  rexp_t rq [2][$];
  mexp_t be_item;

  qbus_target #(.WAIT_STATES(0), .TIMEOUT(TMO)) u0 (
    .clk(clk), .reset(rst), .ce(ce), .addr_i(addr_i), .data_i(data_i), .data_o(d_o[0]),
    .SYNC(SYNC), .DIN(DIN), .DOUT(DOUT), .WTBT(WTBT), .RPLY(rply[0]),
    .mem_addr(m_addr[0]), .mem_rd(m_rd[0]), .mem_wr(m_wr[0]), .mem_be(m_be[0]),
    .mem_wdata(m_wdata[0]), .mem_rdata(m_rdata[0]), .mem_ack(m_ack[0]), .err_o(err[0])
  );

  qbus_target #(.BASE(16'o000000), .WAIT_STATES(3), .TIMEOUT(TMO)) u1 (
    .clk(clk), .reset(rst), .ce(ce), .addr_i(addr_i), .data_i(data_i), .data_o(d_o[1]),
    .SYNC(SYNC), .DIN(DIN), .DOUT(DOUT), .WTBT(WTBT), .RPLY(rply[1]),
    .mem_addr(m_addr[1]), .mem_rd(m_rd[1]), .mem_wr(m_wr[1]), .mem_be(m_be[1]),
    .mem_wdata(m_wdata[1]), .mem_rdata(m_rdata[1]), .mem_ack(m_ack[1]), .err_o(err[1])
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Backend: pops the expected access when a request first appears, acks after ack_lat cycles
  initial begin
    WS[0] = 0; WS[1] = 3;
    for (int k = 0; k < 2; k++) begin
      m_ack[k] = 1'b0; m_rdata[k] = '0; ack_lat[k] = 1;
      req_cnt[k] = 0; req_start[k] = 0; any_req[k] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (!rst && (m_rd[k] || m_wr[k])) begin
          req_cnt[k]++;
          if (req_cnt[k] == 1) begin
            req_start[k] = cyc;
            any_req[k]   = 1'b1;
            chk("mem_expected", 32'(mq[k].size() > 0), 32'd1);
            if (mq[k].size() > 0) begin
              be_item = mq[k].pop_front();
              chk("mem_addr", 32'(m_addr[k]), 32'(be_item.addr));
              chk("mem_be", 32'(m_be[k]), 32'(be_item.be));
              chk("mem_dir", 32'(m_wr[k]), 32'(be_item.wr));
              if (be_item.wr) chk("mem_wdata", 32'(m_wdata[k]), 32'(be_item.wdata));
            end
          end
          m_ack[k] = (ack_lat[k] != 0 && req_cnt[k] == ack_lat[k]);
        end else begin
          req_cnt[k] = 0;
          m_ack[k]   = 1'b0;
        end
      end
    end
  end

  task automatic xfer(input int k, input logic [15:0] a, input logic [15:0] d, input bit rd,
                      input bit wt, input int lat, input logic [15:0] rdv, input bit hold);
    mexp_t me;
    rexp_t re;
    int    t0;
    int    rl;
    bit    got;
    bit    exp_err;
    exp_err  = (lat == 0 || lat > TMO);
    rl       = WS[k] + (exp_err ? TMO : lat);
    me.addr  = a[15:1];
    me.wr    = !rd;
    me.be    = (!rd && wt) ? (a[0] ? 2'b10 : 2'b01) : 2'b11;
    me.wdata = (!rd && wt) ? {d[7:0], d[7:0]} : d;
    mq[k].push_back(me);
    re.rd   = rd;
    re.err  = exp_err;
    re.data = exp_err ? 16'hFFFF : rdv;
    rq[k].push_back(re);
    ack_lat[k] = lat;
    m_rdata[k] = rdv;
    @(posedge clk); #1;
    addr_i = a; data_i = d; WTBT = wt; SYNC = 1'b1; DIN = rd; DOUT = !rd;
    t0  = cyc + 1;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(posedge clk); #1;
      got = rply[k];
    end
    chk("rply_wait", 32'(got), 32'd1);
    if (got) begin
      re = rq[k].pop_front();
      chk("rply_lat", cyc - t0, rl);
      chk("req_lat", req_start[k] - t0, WS[k]);
      chk("req_drop", 32'(m_rd[k] | m_wr[k]), 32'd0);
      chk("err_o", 32'(err[k]), 32'(re.err));
      if (re.rd) chk("data_o", 32'(d_o[k]), 32'(re.data));
    end
    DIN = 1'b0; DOUT = 1'b0; SYNC = hold;
    @(posedge clk); #1;
    chk("rply_drop", 32'(rply[k]), 32'd0);
    chk("err_pulse", 32'(err[k]), 32'd0);
    @(posedge clk); #1;
    chk("mem_q_empty", mq[k].size(), 0);
  endtask

  // Start a cycle that must never produce a backend access or a reply
  task automatic no_reply(input string tag, input logic [15:0] a, input bit rd, input int hold_cyc);
    bit saw;
    saw = 1'b0;
    any_req[0] = 1'b0; any_req[1] = 1'b0;
    @(posedge clk); #1;
    addr_i = a; SYNC = 1'b1; DIN = rd; DOUT = !rd; WTBT = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (i == hold_cyc - 1) begin SYNC = 1'b0; DIN = 1'b0; DOUT = 1'b0; end
      saw = saw | rply[0] | rply[1];
    end
    chk({tag, "_rply"}, 32'(saw), 32'd0);
    chk({tag, "_req"}, 32'(any_req[0] | any_req[1]), 32'd0);
    SYNC = 1'b0; DIN = 1'b0; DOUT = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rply", 32'(rply[0]), 32'd0);
    chk("rst_data_o", 32'(d_o[0]), 32'd0);
    chk("rst_mem_rd", 32'(m_rd[0]), 32'd0);
    chk("rst_mem_wr", 32'(m_wr[0]), 32'd0);
    chk("rst_mem_be", 32'(m_be[0]), 32'd0);
    chk("rst_mem_addr", 32'(m_addr[0]), 32'd0);
    chk("rst_mem_wdata", 32'(m_wdata[0]), 32'd0);
    chk("rst_err", 32'(err[0]), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    xfer(0, 16'o100004, 16'h0000, 1'b1, 1'b0, 1, 16'o123456, 1'b0);
    xfer(0, 16'o100011, 16'h00A5, 1'b0, 1'b1, 2, 16'h0000, 1'b0);
    xfer(0, 16'o100010, 16'h1234, 1'b0, 1'b1, 1, 16'h0000, 1'b0);
    xfer(0, 16'o100020, 16'hBEEF, 1'b0, 1'b0, 1, 16'h0000, 1'b0);
    xfer(1, 16'o000020, 16'hBEEF, 1'b0, 1'b0, 1, 16'h0000, 1'b0);
    xfer(1, 16'o000201, 16'hC3C3, 1'b0, 1'b1, 2, 16'h0000, 1'b0);
    xfer(1, 16'o000200, 16'h0000, 1'b1, 1'b0, 3, 16'h7E81, 1'b0);

    no_reply("miss", 16'o040000, 1'b1, 10);
    no_reply("abort_wait", 16'o000040, 1'b0, 1);

    xfer(0, 16'o100030, 16'h0000, 1'b1, 1'b0, 0, 16'h1111, 1'b0);
    xfer(0, 16'o100032, 16'h0000, 1'b1, 1'b0, TMO, 16'h2468, 1'b0);

    // SYNC stays high between two back-to-back cycles
    xfer(0, 16'o100100, 16'h0000, 1'b1, 1'b0, 1, 16'hA0A0, 1'b1);
    xfer(0, 16'o100102, 16'h0000, 1'b1, 1'b0, 1, 16'h0B0B, 1'b0);

    // Reset while a read sits in REQ with no ack coming
    begin
      mexp_t me;
      me.addr = 15'o40020; me.be = 2'b11; me.wdata = '0; me.wr = 1'b0;
      mq[0].push_back(me);
      ack_lat[0] = 0;
      @(posedge clk); #1;
      addr_i = 16'o100040; SYNC = 1'b1; DIN = 1'b1; DOUT = 1'b0; WTBT = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("pre_rst_mem_rd", 32'(m_rd[0]), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_mem_rd", 32'(m_rd[0]), 32'd0);
      chk("async_rst_rply", 32'(rply[0]), 32'd0);
      chk("async_rst_err", 32'(err[0]), 32'd0);
      chk("async_rst_data_o", 32'(d_o[0]), 32'd0);
      chk("rst_mem_q", mq[0].size(), 0);
      SYNC = 1'b0; DIN = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
    end
    xfer(0, 16'o100042, 16'h0000, 1'b1, 1'b0, 1, 16'h5A5A, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
